uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Standalone 8N1 UART receiver; the receiving end for the 8N1 transmitter already in the design.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first at bit centres and checks the stop bit.
- Delivers each byte with a one-cycle valid pulse, or a framing-error pulse if the stop bit is bad.

Parameters:
- clk_value, 100_000_000, system clock frequency in Hz.
- baud, 9600, line bit rate.
- wait_count, clk_value/baud, clocks per bit (derived; 10416 at defaults).
- half_count, wait_count/2, clocks from start edge to start-bit centre (5208 at defaults).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rxdata  output  8  last correctly framed byte; holds until the next good frame.
- rdone  output  1  one-cycle pulse: rxdata updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset (clk edge with rst=1):
  - rxdata=8'h00, rdone=0, frame_err=0, busy=0, state=IDLE.
  - Counters and bit index cleared.
  - Synchroniser and edge-detect flops preset to 1, so no false start edge after reset.
  - Reset mid-frame aborts the frame with no pulse.
- Input path:
  - 2-flop synchroniser gives rx_s; one more flop gives rx_d.
  - Start edge = rx_d==1 && rx_s==0. Define t0 as the clk edge where this is first true.
- Single counter cnt runs in all non-IDLE states.
- IDLE:
  - busy=0, cnt=0.
  - On start edge go to START and set busy=1.
  - A line held low (break) causes no new frame until a new 1->0 edge occurs.
- START:
  - Count to half_count, i.e. sample at t0+half_count.
  - If rx_s==0: cnt=0, bit index=0, go to DATA.
  - If rx_s==1: glitch; go to IDLE with no pulse.
- DATA:
  - Sample rx_s when cnt==wait_count-1, then reset cnt.
  - Shift into an internal shift register, LSB first; bit i is sampled at t0+half_count+(i+1)*wait_count.
  - After bit 7, go to STOP.
- STOP:
  - Sample rx_s at t0+half_count+9*wait_count.
  - If 1: rxdata<=shift register and rdone=1 for exactly one cycle (the edge after the sample).
  - If 0: frame_err=1 for one cycle; rxdata unchanged.
  - Either way go to IDLE.
- Re-arm timing:
  - A new start edge is accepted no earlier than the cycle after the return to IDLE.
  - Back-to-back frames with no idle gap beyond the stop bit must be received.
- rdone and frame_err are mutually exclusive and never asserted in the same cycle as busy's rising edge.
- rx transitions during a bit period outside the sample instant are ignored; no majority vote.

Test Plan:
- Bench parameters: clk_value=1_000_000, baud=100_000, giving wait_count=10 and half_count=5.
- Reset: hold rst=1 for 3 cycles with rx=1, then release -> rxdata=8'h00, rdone=0, frame_err=0, busy=0; no activity for 50 idle cycles.
- Single frame: drive 8'h41 (start, 1,0,0,0,0,0,1,0, stop=1) at 10 clk/bit -> exactly one rdone pulse; rxdata=8'h41; busy falls after the stop sample; frame_err stays 0.
- Back-to-back frames: 8'hA5 immediately followed by 8'h3C, no gap -> two rdone pulses ~100 cycles apart; rxdata=8'hA5, then 8'h3C.
- Framing error: 8'hFF with stop bit driven 0, then line high -> one frame_err pulse, no rdone; rxdata keeps the previous value.
- Glitch rejection: rx low for 3 cycles, then high -> busy pulses then returns to 0 after half_count; no rdone and no frame_err.
- Reset mid-frame: assert rst during data bit 4 of 8'h55 -> busy=0 next cycle; no pulses. A following clean 8'h12 frame is then received correctly with rdone.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_rx_fsm #(
    parameter int clk_value = 100_000_000,
    parameter int baud      = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rdone,
    output logic       frame_err,
    output logic       busy
);

    localparam int wait_count = clk_value / baud;
    localparam int half_count = wait_count / 2;
    localparam int cnt_w      = $clog2(wait_count + 1);

    localparam logic [cnt_w-1:0] half_last = cnt_w'(half_count - 1);
    localparam logic [cnt_w-1:0] bit_last  = cnt_w'(wait_count - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_d;
    logic             start_edge;

    // Falling edge on the synchronised line marks a candidate start bit
    assign start_edge = rx_d && !rx_s;

    // Two-flop synchroniser plus edge-detect flop; preset high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Receive FSM: one shared counter times the half-bit to the start centre, then full bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rxdata    <= 8'h00;
            rdone     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rdone     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (start_edge) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == half_last) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            // Line went back high before the start-bit centre: treat as noise
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == bit_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            rxdata <= shreg;
                            rdone  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rxdata;
    logic       rdone;
    logic       frame_err;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        bit       is_err;
        bit [7:0] data;
        int       at_cyc;
    } exp_t;

    exp_t exp_q[$];

    uart_rx_fsm #(
        .clk_value(1_000_000),
        .baud     (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rxdata   (rxdata),
        .rdone    (rdone),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame at 10 clk/bit; abort_bit >= 0 resets the DUT midway through that bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_err,
                              input logic [7:0] exp_data, input int abort_bit);
        logic [9:0] bits;
        int e;
        bits = {stop, d, 1'b0};
        e    = cyc;
        if (abort_bit < 0) exp_q.push_back('{exp_err, exp_data, e + 98});
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            if (b == abort_bit) begin
                repeat (5) step();
                rst = 1'b1;
                rx  = 1'b1;
                step();
                chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
                chk("midframe_reset_rxdata", {24'd0, rxdata}, 32'd0);
                step();
                rst = 1'b0;
                return;
            end
            repeat (10) step();
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst && (rdone || frame_err)) begin
            chk("pulse_exclusive", {31'd0, rdone && frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_err, rdone}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind_data_busy", {22'd0, busy, frame_err, rxdata},
                    {22'd0, 1'b0, e.is_err, e.data});
                chk("pulse_cycle", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        int busy_seen;
        int e;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_rxdata", {24'd0, rxdata}, 32'd0);
        chk("reset_rdone", {31'd0, rdone}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy) busy_seen++;
        end
        chk("idle_no_busy", busy_seen, 0);

        send_frame(8'h41, 1'b1, 1'b0, 8'h41, -1);
        repeat (20) step();

        send_frame(8'hA5, 1'b1, 1'b0, 8'hA5, -1);
        send_frame(8'h3C, 1'b1, 1'b0, 8'h3C, -1);
        repeat (20) step();

        send_frame(8'hFF, 1'b0, 1'b1, 8'h3C, -1);
        rx = 1'b1;
        repeat (20) step();
        chk("ferr_rxdata_held", {24'd0, rxdata}, 32'h3C);

        e  = cyc;
        rx = 1'b0;
        repeat (3) step();
        rx = 1'b1;
        while (cyc < e + 4) step();
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        while (cyc < e + 9) step();
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        repeat (20) step();

        send_frame(8'h55, 1'b1, 1'b0, 8'h00, 5);
        repeat (30) step();
        chk("post_reset_idle_busy", {31'd0, busy}, 32'd0);

        send_frame(8'h12, 1'b1, 1'b0, 8'h12, -1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_rxdata", {24'd0, rxdata}, 32'h12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
